// File: rtl/controlador_rega_if.sv
// controlador_rega_if: the controller's command, sensor and display/actuator signals.
// The master side drives commands and raw sensors; the slave side is the controller.
interface controlador_rega_if;
    logic       start;
    logic       stop;
    logic [1:0] nivel_raw;
    logic       limpa_raw;
    logic       mista_raw;
    logic [3:0] umid;
    logic       S;
    logic [3:0] ContA;
    logic [1:0] ContB;
    logic       Nv1;
    logic       Nv0;
    logic       Limp;
    logic       Mist;
    logic       bomba;
    logic [3:0] valvula;
    logic       alarme;

    modport master (
        output start, stop, nivel_raw, limpa_raw, mista_raw, umid,
        input  S, ContA, ContB, Nv1, Nv0, Limp, Mist, bomba, valvula, alarme
    );

    modport slave (
        input  start, stop, nivel_raw, limpa_raw, mista_raw, umid,
        output S, ContA, ContB, Nv1, Nv0, Limp, Mist, bomba, valvula, alarme
    );
endinterface

// File: rtl/controlador_rega.sv
// controlador_rega: irrigation sequencer sitting in front of the 4-digit display
// selector. Runs up to four zones for IRR_TIME time units each, with a one-tick
// pause between zones, and raises an alarm when the tank reads empty.
// Optional build macro: SKIP_WET_ZONE_EN (zones whose umid bit is set are skipped).
module controlador_rega #(
    parameter int TICK_DIV  = 50000000,
    parameter int SCAN_DIV  = 50000,
    parameter int IRR_TIME  = 10,
    parameter int NUM_ZONES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    controlador_rega_if.slave bus
);
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [3:0]    IRR_LOAD  = 4'(IRR_TIME);
    localparam logic [1:0]    LAST_ZONE = 2'(NUM_ZONES - 1);

    typedef enum logic [1:0] {IDLE, IRRIGATE, PAUSE, ALARM} state_t;

    logic [1:0]    lvl_s1_q, lvl_s2_q;
    logic          limp_s1_q, limp_s2_q, mist_s1_q, mist_s2_q;
    logic [TW-1:0] presc_q, presc_d;
    logic [SW-1:0] scan_q, scan_d;
    logic          s_q, s_d;
    state_t        state_q, state_d;
    logic [3:0]    conta_q, conta_d;
    logic [1:0]    contb_q, contb_d;
    logic          bomba_q, bomba_d;
    logic [3:0]    valv_q, valv_d;
    logic          alarme_q, alarme_d;

    logic          tick, lvl_empty;
    logic          first_ok, next_ok;
    logic [1:0]    first_zone, next_zone;

    assign tick      = (presc_q == TICK_LAST);
    assign lvl_empty = (lvl_s2_q == 2'b00);

`ifdef SKIP_WET_ZONE_EN
    // Lowest dry zone overall (first) and lowest dry zone above the current one (next)
    always_comb begin
        first_ok   = 1'b0;
        first_zone = 2'd0;
        next_ok    = 1'b0;
        next_zone  = 2'd0;
        for (int i = NUM_ZONES - 1; i >= 0; i--) begin
            if (!bus.umid[i]) begin
                first_ok   = 1'b1;
                first_zone = 2'(i);
                if (i > int'(contb_q)) begin
                    next_ok   = 1'b1;
                    next_zone = 2'(i);
                end
            end
        end
    end
`else
    // Zones run strictly in order; umid has no effect in this build
    logic unused_umid;
    assign unused_umid = ^bus.umid;
    assign first_ok    = 1'b1;
    assign first_zone  = 2'd0;
    assign next_ok     = (contb_q != LAST_ZONE);
    assign next_zone   = contb_q + 2'd1;
`endif

    // Sequencer next state: stop beats empty tank, which beats the tick
    always_comb begin
        state_d = state_q;
        conta_d = conta_q;
        contb_d = contb_q;
        case (state_q)
            IDLE: begin
                // With every zone wet a start is simply dropped, alarm included
                if (bus.start && first_ok) begin
                    if (lvl_empty) begin
                        state_d = ALARM;
                    end else begin
                        state_d = IRRIGATE;
                        conta_d = IRR_LOAD;
                        contb_d = first_zone;
                    end
                end
            end
            IRRIGATE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    conta_d = 4'd0;
                    contb_d = 2'd0;
                end else if (lvl_empty) begin
                    state_d = ALARM;
                end else if (tick) begin
                    if (conta_q > 4'd1) begin
                        conta_d = conta_q - 4'd1;
                    end else begin
                        conta_d = 4'd0;
                        if (next_ok) begin
                            state_d = PAUSE;
                            contb_d = next_zone;
                        end else begin
                            state_d = IDLE;
                            contb_d = 2'd0;
                        end
                    end
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    conta_d = 4'd0;
                    contb_d = 2'd0;
                end else if (lvl_empty) begin
                    state_d = ALARM;
                end else if (tick) begin
                    state_d = IRRIGATE;
                    conta_d = IRR_LOAD;
                end
            end
            ALARM: begin
                // Counters hold while alarmed; acknowledge only once the tank has water
                if (bus.start && !lvl_empty) begin
                    state_d = IDLE;
                    conta_d = 4'd0;
                    contb_d = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
                conta_d = 4'd0;
                contb_d = 2'd0;
            end
        endcase
    end

    // Actuator outputs follow the next state so they register with the transition
    always_comb begin
        bomba_d  = (state_d == IRRIGATE);
        valv_d   = bomba_d ? (4'b0001 << contb_d) : 4'b0000;
        alarme_d = (state_d == ALARM);
    end

    // Time-unit prescaler, restarted on each entry to IRRIGATE so the first
    // decrement lands a full tick period after the valve opens
    always_comb begin
        if ((state_d == IRRIGATE && state_q != IRRIGATE) || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + TW'(1);
        end
    end

    // Free-running digit-scan divider
    always_comb begin
        s_d = s_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            s_d    = ~s_q;
        end else begin
            scan_d = scan_q + SW'(1);
        end
    end

    // Two-flop synchronizers for the asynchronous tank and water-quality sensors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_s1_q  <= 2'b00;
            lvl_s2_q  <= 2'b00;
            limp_s1_q <= 1'b0;
            limp_s2_q <= 1'b0;
            mist_s1_q <= 1'b0;
            mist_s2_q <= 1'b0;
        end else begin
            lvl_s1_q  <= bus.nivel_raw;
            lvl_s2_q  <= lvl_s1_q;
            limp_s1_q <= bus.limpa_raw;
            limp_s2_q <= limp_s1_q;
            mist_s1_q <= bus.mista_raw;
            mist_s2_q <= mist_s1_q;
        end
    end

    // Sequencer state, counters, dividers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            conta_q  <= 4'd0;
            contb_q  <= 2'd0;
            presc_q  <= '0;
            scan_q   <= '0;
            s_q      <= 1'b0;
            bomba_q  <= 1'b0;
            valv_q   <= 4'b0000;
            alarme_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            conta_q  <= conta_d;
            contb_q  <= contb_d;
            presc_q  <= presc_d;
            scan_q   <= scan_d;
            s_q      <= s_d;
            bomba_q  <= bomba_d;
            valv_q   <= valv_d;
            alarme_q <= alarme_d;
        end
    end

    assign bus.S       = s_q;
    assign bus.ContA   = conta_q;
    assign bus.ContB   = contb_q;
    assign bus.Nv1     = lvl_s2_q[1];
    assign bus.Nv0     = lvl_s2_q[0];
    assign bus.Limp    = limp_s2_q;
    assign bus.Mist    = mist_s2_q;
    assign bus.bomba   = bomba_q;
    assign bus.valvula = valv_q;
    assign bus.alarme  = alarme_q;
endmodule

// File: tb/tb_controlador_rega.sv
// tb_controlador_rega: scenario tasks for the irrigation sequencer. Expected
// outputs come from a schedule model: each listed zone irrigates IRR_TIME*TICK_DIV
// cycles, then a TICK_DIV pause, with stop/empty-tank events overlaid.
module tb_controlador_rega;
    localparam int TD = 4;
    localparam int SD = 2;
    localparam int IT = 3;
    localparam int NZ = 4;
    localparam int P  = IT * TD + TD;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc;
    int   zl[$];
    logic [1:0] nv_p1, nv_p2;
    logic lm_p1, lm_p2, ms_p1, ms_p2;

    controlador_rega_if bus();

    controlador_rega #(.TICK_DIV(TD), .SCAN_DIV(SD), .IRR_TIME(IT), .NUM_ZONES(NZ)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release, used for the expected scan clock
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Advance to the next falling edge, remembering what the synchronizers sampled
    task automatic adv();
        nv_p2 = nv_p1; nv_p1 = bus.nivel_raw;
        lm_p2 = lm_p1; lm_p1 = bus.limpa_raw;
        ms_p2 = ms_p1; ms_p1 = bus.mista_raw;
        @(negedge clk);
    endtask

    task automatic clear_hist();
        nv_p1 = 2'b00; nv_p2 = 2'b00;
        lm_p1 = 1'b0;  lm_p2 = 1'b0;
        ms_p1 = 1'b0;  ms_p2 = 1'b0;
    endtask

    // Zones that a cycle will visit, in order
    task automatic build_list();
        zl.delete();
        for (int i = 0; i < NZ; i++) begin
`ifdef SKIP_WET_ZONE_EN
            if (!bus.umid[i]) zl.push_back(i);
`else
            zl.push_back(i);
`endif
        end
    endtask

    // Undisturbed run: outputs o cycles after the start was taken
    function automatic void sched(input int o, output logic [3:0] a,
                                  output logic [1:0] b, output logic pump);
        int k, r, eo;
        a = 4'd0; b = 2'd0; pump = 1'b0;
        if (zl.size() == 0) return;
        eo = (zl.size() - 1) * P + IT * TD;
        if (o >= eo) return;
        k = o / P;
        r = o % P;
        if (r < IT * TD) begin
            a = 4'(IT - r / TD);
            b = 2'(zl[k]);
            pump = 1'b1;
        end else begin
            b = 2'(zl[k + 1]);
        end
    endfunction

    task automatic settle_level(input logic [1:0] lvl);
        bus.nivel_raw = lvl;
        repeat (3) adv();
    endtask

    // kind 0: plain run, 1: stop at offset 'at', 2: tank empties at offset 'at'
    task automatic run_case(input int kind, input int at);
        logic [3:0] ea, ha, evv;
        logic [1:0] eb, hb;
        logic ep, hp, eal;
        int eo, stop_o, alarm_o;
        build_list();
        eo = (zl.size() == 0) ? 0 : (zl.size() - 1) * P + IT * TD;
        stop_o  = (kind == 1) ? at + 1 : NEVER;
        alarm_o = (kind == 2 && zl.size() != 0 && at + 3 <= eo) ? at + 3 : NEVER;
        sched(at + 2, ha, hb, hp);
        bus.start = 1'b1;
        adv();
        bus.start = 1'b0;
        for (int o = 0; o <= eo + 5; o++) begin
            sched(o, ea, eb, ep);
            eal = 1'b0;
            if (o >= stop_o) begin ea = 4'd0; eb = 2'd0; ep = 1'b0; end
            if (o >= alarm_o) begin ea = ha; eb = hb; ep = 1'b0; eal = 1'b1; end
            evv = ep ? (4'b0001 << eb) : 4'b0000;
            n_cmp++;
            if ({bus.ContA, bus.ContB, bus.bomba, bus.valvula, bus.alarme} !== {ea, eb, ep, evv, eal}) begin
                n_bad++;
                $display("FAIL run k=%0d at=%0d o=%0d got A=%0d B=%0d pump=%b valv=%b alm=%b expected A=%0d B=%0d pump=%b valv=%b alm=%b",
                         kind, at, o, bus.ContA, bus.ContB, bus.bomba, bus.valvula, bus.alarme, ea, eb, ep, evv, eal);
            end
            n_cmp++;
            if ({bus.Nv1, bus.Nv0, bus.Limp, bus.Mist, bus.S} !== {nv_p2, lm_p2, ms_p2, 1'((cyc / SD) % 2)}) begin
                n_bad++;
                $display("FAIL sensors o=%0d got Nv=%b%b Limp=%b Mist=%b S=%b expected Nv=%b Limp=%b Mist=%b S=%0d",
                         o, bus.Nv1, bus.Nv0, bus.Limp, bus.Mist, bus.S, nv_p2, lm_p2, ms_p2, (cyc / SD) % 2);
            end
            bus.stop      = (kind == 1 && o == at);
            bus.nivel_raw = (kind == 2 && o >= at) ? 2'b00 : 2'($urandom_range(1, 3));
            bus.limpa_raw = 1'($urandom);
            bus.mista_raw = 1'($urandom);
            adv();
        end
        bus.stop = 1'b0;
        bus.nivel_raw = 2'($urandom_range(1, 3));
        adv();
        adv();
        if (alarm_o != NEVER) begin
            n_cmp++;
            if (bus.alarme !== 1'b1) begin
                n_bad++;
                $display("FAIL alarm_hold got alarme=%b expected 1", bus.alarme);
            end
            bus.start = 1'b1;
            adv();
            bus.start = 1'b0;
            n_cmp++;
            if ({bus.ContA, bus.ContB, bus.bomba, bus.valvula, bus.alarme} !== 12'd0) begin
                n_bad++;
                $display("FAIL alarm_ack got A=%0d B=%0d pump=%b valv=%b alm=%b expected all 0",
                         bus.ContA, bus.ContB, bus.bomba, bus.valvula, bus.alarme);
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.stop = 0; bus.nivel_raw = 2'b00;
        bus.limpa_raw = 0; bus.mista_raw = 0; bus.umid = 4'b0000;
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({bus.S, bus.ContA, bus.ContB, bus.Nv1, bus.Nv0, bus.Limp, bus.Mist, bus.bomba, bus.valvula, bus.alarme} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_initial got A=%0d B=%0d pump=%b alm=%b expected all 0", bus.ContA, bus.ContB, bus.bomba, bus.alarme);
        end
        @(negedge clk);
        clear_hist();
        rst_n = 1'b1;
        bus.limpa_raw = 1'b1;
        settle_level(2'b11);
        bus.start = 1'b1; adv(); bus.start = 1'b0;
        adv(); adv();
        n_cmp++;
        if (bus.bomba !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_prerun got bomba=%b expected 1", bus.bomba);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.S, bus.ContA, bus.ContB, bus.Nv1, bus.Nv0, bus.Limp, bus.Mist, bus.bomba, bus.valvula, bus.alarme} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_async got A=%0d B=%0d pump=%b valv=%b Nv=%b%b Limp=%b expected all 0",
                     bus.ContA, bus.ContB, bus.bomba, bus.valvula, bus.Nv1, bus.Nv0, bus.Limp);
        end
        @(negedge clk);
        clear_hist();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            adv();
            n_cmp++;
            if (bus.S !== 1'((cyc / SD) % 2)) begin
                n_bad++;
                $display("FAIL scan_clock edge=%0d got S=%b expected %0d", cyc, bus.S, (cyc / SD) % 2);
            end
        end
    endtask

    task automatic test_sync();
        bus.limpa_raw = 0; bus.mista_raw = 0;
        settle_level(2'b11);
        bus.limpa_raw = 1; bus.mista_raw = 0; bus.nivel_raw = 2'b01;
        adv();
        n_cmp++;
        if ({bus.Limp, bus.Mist, bus.Nv1, bus.Nv0} !== 4'b0011) begin
            n_bad++;
            $display("FAIL sync_1cycle got Limp=%b Mist=%b Nv=%b%b expected 0 0 11", bus.Limp, bus.Mist, bus.Nv1, bus.Nv0);
        end
        adv();
        n_cmp++;
        if ({bus.Limp, bus.Mist, bus.Nv1, bus.Nv0} !== 4'b1001) begin
            n_bad++;
            $display("FAIL sync_2cycle got Limp=%b Mist=%b Nv=%b%b expected 1 0 01", bus.Limp, bus.Mist, bus.Nv1, bus.Nv0);
        end
        bus.limpa_raw = 0; bus.mista_raw = 1;
        adv();
        n_cmp++;
        if ({bus.Limp, bus.Mist} !== 2'b10) begin
            n_bad++;
            $display("FAIL sync_toggle1 got Limp=%b Mist=%b expected 1 0", bus.Limp, bus.Mist);
        end
        adv();
        n_cmp++;
        if ({bus.Limp, bus.Mist} !== 2'b01) begin
            n_bad++;
            $display("FAIL sync_toggle2 got Limp=%b Mist=%b expected 0 1", bus.Limp, bus.Mist);
        end
        settle_level(2'b11);
    endtask

    task automatic test_full_run();
        bus.umid = 4'b0000;
        settle_level(2'b11);
        run_case(0, 0);
    endtask

    task automatic test_empty_tank();
        bus.umid = 4'b0000;
        settle_level(2'b11);
        run_case(2, P + TD);
    endtask

    task automatic test_simultaneous();
        logic [3:0] ea; logic [1:0] eb; logic ep;
        bus.umid = 4'b0000;
        build_list();
        settle_level(2'b11);
        bus.start = 1'b1; adv(); bus.start = 1'b0;
        for (int o = 0; o < 13; o++) begin
            sched(o, ea, eb, ep);
            if (o >= 2 * TD) begin ea = 4'd0; eb = 2'd0; ep = 1'b0; end
            n_cmp++;
            if ({bus.ContA, bus.ContB, bus.bomba, bus.alarme} !== {ea, eb, ep, 1'b0}) begin
                n_bad++;
                $display("FAIL stop_vs_empty o=%0d got A=%0d B=%0d pump=%b alm=%b expected A=%0d B=%0d pump=%b alm=0",
                         o, bus.ContA, bus.ContB, bus.bomba, bus.alarme, ea, eb, ep);
            end
            if (o == 2 * TD - 3) bus.nivel_raw = 2'b00;
            bus.stop = (o == 2 * TD - 1);
            adv();
        end
        bus.start = 1'b1; adv(); bus.start = 1'b0;
        n_cmp++;
        if ({bus.ContA, bus.ContB, bus.bomba, bus.valvula, bus.alarme} !== 12'd1) begin
            n_bad++;
            $display("FAIL idle_empty_start got A=%0d B=%0d pump=%b valv=%b alm=%b expected alarm only",
                     bus.ContA, bus.ContB, bus.bomba, bus.valvula, bus.alarme);
        end
        settle_level(2'b11);
        bus.start = 1'b1; adv(); bus.start = 1'b0;
        n_cmp++;
        if (bus.alarme !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_alarm_ack got alarme=%b expected 0", bus.alarme);
        end
    endtask

`ifdef SKIP_WET_ZONE_EN
    task automatic test_skip_wet();
        bus.umid = 4'b0101;
        settle_level(2'b11);
        run_case(0, 0);
        bus.umid = 4'b1111;
        settle_level(2'b00);
        bus.start = 1'b1; adv(); bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({bus.ContA, bus.ContB, bus.bomba, bus.valvula, bus.alarme} !== 12'd0) begin
                n_bad++;
                $display("FAIL all_wet i=%0d got A=%0d B=%0d pump=%b alm=%b expected all 0",
                         i, bus.ContA, bus.ContB, bus.bomba, bus.alarme);
            end
            adv();
        end
        settle_level(2'b11);
    endtask
`endif

    task automatic test_random();
        int kind;
        for (int n = 0; n < 12; n++) begin
            bus.umid = 4'($urandom);
            build_list();
            kind = (zl.size() == 0) ? 0 : int'($urandom_range(0, 2));
            settle_level(2'($urandom_range(1, 3)));
            run_case(kind, int'($urandom_range(0, 64)));
        end
    endtask

    initial begin
        clear_hist();
        test_reset();
        test_sync();
        test_full_run();
        test_empty_tank();
        test_simultaneous();
`ifdef SKIP_WET_ZONE_EN
        test_skip_wet();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/controlador_rega.md
Name: controlador_rega

Overview:
- Irrigation sequencing controller.
- Sits directly upstream of the four-digit display selector. It drives:
  - ContA: remaining time units
  - ContB: active zone
  - Nv1/Nv0: synchronized tank level
  - Limp/Mist: synchronized water-quality flags
  - S: digit-scan clock
- Sequences up to four irrigation zones with a fixed per-zone time. Drives the pump and zone valves, and raises an alarm on an empty tank.

Parameters:
- TICK_DIV, 50000000, clk cycles per irrigation time unit (>=2)
- SCAN_DIV, 50000, clk cycles per half-period of S (>=1)
- IRR_TIME, 10, time units per zone, 1..15
- NUM_ZONES, 4, zones sequenced, 1..4

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  synchronous level; begin cycle / acknowledge alarm
- stop  in  1  synchronous level; abort cycle
- nivel_raw  in  2  async tank level: 00 empty, 01 low, 10 mid, 11 full
- limpa_raw  in  1  async clean-water sensor
- mista_raw  in  1  async mixed-water sensor
- umid  in  4  per-zone wet sensor; used only with SKIP_WET_ZONE_EN
- S  out  1  scan clock to the display selector
- ContA  out  4  remaining time units of the current zone
- ContB  out  2  current zone index
- Nv1, Nv0  out  1 each  synchronized level
- Limp, Mist  out  1 each  synchronized quality flags
- bomba  out  1  pump enable
- valvula  out  4  one-hot zone valve
- alarme  out  1  empty-tank alarm

Behaviour:

Clocking and reset:
- One clock, clk. Reset is asynchronous and active-low via rst_n. All flops clear on rst_n=0.
- Reset values: every output is 0; state is IDLE; prescaler and scan divider are 0.

Input synchronization:
- nivel_raw, limpa_raw and mista_raw each pass through a 2-flop synchronizer.
- Nv1/Nv0/Limp/Mist are the second-stage values, i.e. 2 cycles of latency.
- The FSM uses only the synchronized level.

Prescaler:
- Counts 0..TICK_DIV-1 and wraps.
- tick is high for 1 cycle at TICK_DIV-1.
- It is cleared on every FSM entry to IRRIGATE, so the first decrement falls exactly TICK_DIV cycles after entry.

Scan divider:
- S toggles every SCAN_DIV cycles. It free-runs in all states, including ALARM.

FSM states: IDLE, IRRIGATE, PAUSE, ALARM.
- IDLE:
  - bomba=0, valvula=0, ContA=0, ContB=0.
  - start=1 with level 00 -> ALARM.
  - start=1 with level !=00 -> ContA<=IRR_TIME, ContB<=first zone, -> IRRIGATE.
- IRRIGATE:
  - bomba=1, valvula=1<<ContB.
  - On tick with ContA>1: ContA decrements.
  - On tick with ContA==1: ContA<=0.
    - If ContB is the last zone -> IDLE.
    - Otherwise ContB<=next zone, -> PAUSE.
- PAUSE:
  - bomba=0, valvula=0, lasts exactly one tick period.
  - On tick: ContA<=IRR_TIME, -> IRRIGATE.
- ALARM:
  - alarme=1, bomba=0, valvula=0, ContA/ContB hold.
  - start=1 and level !=00 -> IDLE. Counters clear and alarme drops on the next cycle.

Priorities, applied within one cycle:
1. stop (from IRRIGATE or PAUSE) -> IDLE.
2. level==00 (from IRRIGATE or PAUSE) -> ALARM.
3. tick.
- stop in ALARM is ignored.
- Outputs are registered; bomba/valvula change in the cycle after the transition decision.

Optional Feature:
- Macro: SKIP_WET_ZONE_EN.
- Defined:
  - "First zone" and "next zone" are the lowest index >= candidate with umid[i]=0.
  - If no remaining zone is dry, the cycle ends -> IDLE.
  - If all zones are wet at start -> stay IDLE. ContA/ContB stay 0 and no ALARM is raised, even at level 00.
- Not defined:
  - umid is ignored. Zones run 0..NUM_ZONES-1 in order; first zone is 0 and next zone is ContB+1.

Test Plan (TICK_DIV=4, SCAN_DIV=2, IRR_TIME=3, NUM_ZONES=4, nivel_raw=11):
1. Reset: rst_n low mid-cycle -> all outputs 0 immediately, with no clk edge needed. Release, then 10 cycles -> S toggles every 2 cycles.
2. Full run: 1-cycle start pulse -> ContA=3, ContB=0, valvula=0001, bomba=1. ContA goes 3->2->1->0 at 4-cycle spacing. PAUSE lasts 4 cycles with bomba=0. Zones 1,2,3 follow. After zone 3, IDLE with bomba=0.
3. Empty tank mid-run: nivel_raw=00 during zone 1 with ContA=2 -> alarme=1 and bomba=0 within 3 cycles, ContA=2 and ContB=1 held. Then nivel_raw=10 plus start -> IDLE, all zero.
4. Simultaneous: stop and level 00 arrive in the same cycle as a tick in IRRIGATE -> IDLE, alarme stays 0. Start with level 00 in IDLE -> ALARM.
5. Synchronizer: toggle limpa_raw/mista_raw -> Limp/Mist follow after exactly 2 cycles. nivel_raw=01 -> Nv1=0, Nv0=1.
6. With SKIP_WET_ZONE_EN and umid=0101: start -> zone 1 runs, then zone 3 runs, then IDLE. With umid=1111: start -> remains IDLE.
